// File: rtl/csr_block_loader_pkg.sv
// csr_block_loader_pkg
//   Shared definitions for the CSR block loader: chunk-count helper, bit
//   positions of the error flags in the CSR status word, and the fill-FSM
//   state encoding.
package csr_block_loader_pkg;

  // Number of window-sized chunks needed to cover one block (rounded up).
  function automatic int unsigned NUM_CHUNKS_F(input int unsigned block_words,
                                               input int unsigned win_words);
    return (block_words + win_words - 1) / win_words;
  endfunction

  localparam int unsigned ERR_INCOMPLETE_BIT = 0;
  localparam int unsigned ERR_RANGE_BIT      = 1;
  localparam int unsigned ERR_W              = 2;

  typedef enum logic [0:0] {
    FILL_ST  = 1'b0,
    STALL_ST = 1'b1
  } fill_state_t;

endpackage

// File: rtl/blk_buf_queue.sv
// blk_buf_queue
//   NUM_BUF block buffers used as a ring: one buffer is being filled at
//   fill_ptr, full buffers are drained in order from rd_ptr.
//   Ports:
//     clk, resetn        clock, asynchronous active-low reset
//     clr                synchronous flush (all buffers empty and zeroed)
//     fill_we/fill_wdata per-word write into the buffer at fill_ptr
//     fill_discard       zero the buffer at fill_ptr (dominates fill_we)
//     push, push_last    mark fill buffer full, record its last flag
//     pop                release the buffer at rd_ptr
//     rd_valid/rd_data/rd_last  head buffer, word 0 in the MSBs
//     count, all_full    number of full buffers
module blk_buf_queue #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BLOCK_WORDS = 16,
  parameter int unsigned NUM_BUF     = 2,
  localparam int unsigned PTR_W      = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1,
  localparam int unsigned CNT_W      = $clog2(NUM_BUF + 1)
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                clr,
  input  logic [BLOCK_WORDS-1:0]              fill_we,
  input  logic [BLOCK_WORDS-1:0][DATA_W-1:0]  fill_wdata,
  input  logic                                fill_discard,
  input  logic                                push,
  input  logic                                push_last,
  input  logic                                pop,
  output logic                                rd_valid,
  output logic [BLOCK_WORDS*DATA_W-1:0]       rd_data,
  output logic                                rd_last,
  output logic [CNT_W-1:0]                    count,
  output logic                                all_full
);

  logic [DATA_W-1:0] mem [NUM_BUF][BLOCK_WORDS];
  logic [NUM_BUF-1:0] full_q;
  logic [NUM_BUF-1:0] last_q;
  logic [PTR_W-1:0]   fill_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               push_ok;
  logic               pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_BUF - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push_ok = push && !full_q[fill_ptr];
  assign pop_ok  = pop && full_q[rd_ptr];

  // Buffers are zeroed when released, so every empty buffer starts a new
  // block with all words zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned b = 0; b < NUM_BUF; b++)
        for (int unsigned w = 0; w < BLOCK_WORDS; w++)
          mem[b][w] <= '0;
      full_q   <= '0;
      last_q   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
    end else if (clr) begin
      for (int unsigned b = 0; b < NUM_BUF; b++)
        for (int unsigned w = 0; w < BLOCK_WORDS; w++)
          mem[b][w] <= '0;
      full_q   <= '0;
      last_q   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
    end else begin
      for (int unsigned w = 0; w < BLOCK_WORDS; w++) begin
        if (fill_discard)
          mem[fill_ptr][w] <= '0;
        else if (fill_we[w])
          mem[fill_ptr][w] <= fill_wdata[w];
      end
      if (pop_ok) begin
        for (int unsigned w = 0; w < BLOCK_WORDS; w++)
          mem[rd_ptr][w] <= '0;
        full_q[rd_ptr] <= 1'b0;
        last_q[rd_ptr] <= 1'b0;
        rd_ptr         <= ptr_inc(rd_ptr);
      end
      if (push_ok) begin
        full_q[fill_ptr] <= 1'b1;
        last_q[fill_ptr] <= push_last;
        fill_ptr         <= ptr_inc(fill_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_valid = full_q[rd_ptr];
  assign rd_last  = last_q[rd_ptr];
  assign count    = count_q;
  assign all_full = (count_q == CNT_W'(NUM_BUF));

  always_comb begin
    rd_data = '0;
    for (int unsigned w = 0; w < BLOCK_WORDS; w++)
      rd_data[(BLOCK_WORDS - 1 - w) * DATA_W +: DATA_W] = mem[rd_ptr][w];
  end

endmodule

// File: rtl/csr_block_loader.sv
// csr_block_loader
//   Collects DATA_W-bit words through a WIN_WORDS-register CSR window and
//   commits the window into chunk slots of a BLOCK_WORDS-word block. Completed
//   blocks are queued in NUM_BUF buffers and streamed to the compute core.
//   Build option: CSR_BLOCK_LOADER_BSWAP_EN reverses the byte order of every
//   word as it is committed (little-endian window -> big-endian block).
//   Ports:
//     clk, resetn                    clock, asynchronous active-low reset
//     wr_en/wr_idx/wr_data/wr_strb   byte-masked window register write
//     cmd_valid/cmd_ready            commit handshake
//     cmd_chunk/cmd_final/cmd_msg_last  commit target and block framing
//     clr                            synchronous flush, dominates all inputs
//     blk_valid/blk_ready/blk_data/blk_last  block stream, word 0 in MSBs
//     stat_full/stat_count           queue occupancy
//     err_incomplete/err_range       sticky error flags
module csr_block_loader
  import csr_block_loader_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WIN_WORDS   = 7,
  parameter int unsigned BLOCK_WORDS = 16,
  parameter int unsigned NUM_BUF     = 2,
  parameter int unsigned CHUNK_W     = 3,
  localparam int unsigned IDX_W      = (WIN_WORDS > 1) ? $clog2(WIN_WORDS) : 1,
  localparam int unsigned CNT_W      = $clog2(NUM_BUF + 1)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          wr_en,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [DATA_W/8-1:0]           wr_strb,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [CHUNK_W-1:0]            cmd_chunk,
  input  logic                          cmd_final,
  input  logic                          cmd_msg_last,
  input  logic                          clr,
  output logic                          blk_valid,
  input  logic                          blk_ready,
  output logic [BLOCK_WORDS*DATA_W-1:0] blk_data,
  output logic                          blk_last,
  output logic                          stat_full,
  output logic [CNT_W-1:0]              stat_count,
  output logic                          err_incomplete,
  output logic                          err_range
);

  localparam int unsigned NUM_CHUNKS = NUM_CHUNKS_F(BLOCK_WORDS, WIN_WORDS);

  logic [DATA_W-1:0]                win [WIN_WORDS];
  logic [NUM_CHUNKS-1:0]            mask_q;
  logic [NUM_CHUNKS-1:0]            hit;
  logic [NUM_CHUNKS-1:0]            mask_all;
  logic [ERR_W-1:0]                 err_q;
  fill_state_t                      state_q;
  fill_state_t                      state_d;
  logic                             commit;
  logic                             chunk_ok;
  logic                             wr_ok;
  logic                             final_commit;
  logic                             push;
  logic                             discard;
  logic                             pop;
  logic [BLOCK_WORDS-1:0]           fill_we;
  logic [BLOCK_WORDS-1:0][DATA_W-1:0] fill_wdata;
  logic [CNT_W-1:0]                 q_count;

  function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
`ifdef CSR_BLOCK_LOADER_BSWAP_EN
    for (int unsigned b = 0; b < DATA_W / 8; b++)
      r[8*b +: 8] = w[DATA_W - 8 - 8*b +: 8];
`else
    r = w;
`endif
    return r;
  endfunction

  assign commit       = cmd_valid && cmd_ready;
  assign chunk_ok     = 32'(cmd_chunk) < NUM_CHUNKS;
  assign wr_ok        = 32'(wr_idx) < WIN_WORDS;
  assign final_commit = commit && cmd_final;
  assign mask_all     = mask_q | hit;
  assign push         = final_commit && (&mask_all);
  assign discard      = final_commit && !(&mask_all);
  assign pop          = blk_valid && blk_ready;

  always_comb begin
    hit = '0;
    for (int unsigned c = 0; c < NUM_CHUNKS; c++)
      hit[c] = commit && (cmd_chunk == CHUNK_W'(c));
  end

  // Block word w is always fed from window word w % WIN_WORDS; only the write
  // enable depends on the chunk, and words past the block end never exist, so
  // last-chunk truncation needs no extra logic.
  always_comb begin
    fill_we    = '0;
    fill_wdata = '0;
    for (int unsigned w = 0; w < BLOCK_WORDS; w++) begin
      fill_we[w]    = commit && (cmd_chunk == CHUNK_W'(w / WIN_WORDS));
      fill_wdata[w] = xform(win[w % WIN_WORDS]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < WIN_WORDS; i++)
        win[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < WIN_WORDS; i++)
        win[i] <= '0;
    end else if (wr_en && wr_ok) begin
      for (int unsigned i = 0; i < WIN_WORDS; i++)
        if (wr_idx == IDX_W'(i))
          for (int unsigned b = 0; b < DATA_W / 8; b++)
            if (wr_strb[b])
              win[i][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mask_q <= '0;
      err_q  <= '0;
    end else if (clr) begin
      mask_q <= '0;
      err_q  <= '0;
    end else begin
      mask_q <= final_commit ? '0 : mask_all;
      if (discard)
        err_q[ERR_INCOMPLETE_BIT] <= 1'b1;
      if ((commit && !chunk_ok) || (wr_en && !wr_ok))
        err_q[ERR_RANGE_BIT] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state_q <= FILL_ST;
    else if (clr)
      state_q <= FILL_ST;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL_ST:  if (push && !pop && q_count == CNT_W'(NUM_BUF - 1)) state_d = STALL_ST;
      STALL_ST: if (pop) state_d = FILL_ST;
      default:  state_d = FILL_ST;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == FILL_ST);
  end

  blk_buf_queue #(
    .DATA_W      (DATA_W),
    .BLOCK_WORDS (BLOCK_WORDS),
    .NUM_BUF     (NUM_BUF)
  ) u_queue (
    .clk          (clk),
    .resetn       (resetn),
    .clr          (clr),
    .fill_we      (fill_we),
    .fill_wdata   (fill_wdata),
    .fill_discard (discard),
    .push         (push),
    .push_last    (cmd_msg_last),
    .pop          (pop),
    .rd_valid     (blk_valid),
    .rd_data      (blk_data),
    .rd_last      (blk_last),
    .count        (q_count),
    .all_full     (stat_full)
  );

  assign stat_count     = q_count;
  assign err_incomplete = err_q[ERR_INCOMPLETE_BIT];
  assign err_range      = err_q[ERR_RANGE_BIT];

endmodule
